// File: rtl/mac_array_acc.sv
// mac_array_acc: lane-parallel signed MAC with CONV partial-sum add, FC dot-product accumulation and quantised output
module mac_array_acc #(
    parameter int LANES         = 120,
    parameter int DATA_W        = 16,
    parameter int LANES_PER_KER = 8,
    parameter int KER_NUM       = 15,
    parameter int PSUM_W        = 28,
    parameter int ACC_W         = 40,
    parameter int OUT_W         = 16,
    parameter int FRAC_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [LANES-1:0]            lane_en,
    input  logic [LANES*DATA_W-1:0]     img,
    input  logic [KER_NUM*DATA_W-1:0]   ker,
    input  logic [LANES*PSUM_W-1:0]     psum,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [LANES*ACC_W-1:0]      acc_out,
    output logic [LANES*OUT_W-1:0]      q_out,
    output logic [LANES-1:0]            sat_flag,
    output logic                        busy
);
    localparam int PW2  = 2 * DATA_W;
    localparam int QT_W = ACC_W + 1 - FRAC_W;

    logic adv, emit, fc_open;
    logic s1_vld, s1_mode, s1_first, s1_last;
    logic s2_vld, s2_mode, s2_first, s2_last;
    logic [LANES-1:0] s1_en;
    logic [LANES*DATA_W-1:0] s1_img;
    logic [KER_NUM*DATA_W-1:0] s1_ker;
    logic [LANES*PSUM_W-1:0] s1_psum, s2_psum;

    assign adv = !out_vld || out_rdy;
    assign in_rdy = adv;
    assign busy = s1_vld || s2_vld || out_vld || fc_open;
    assign emit = s2_vld && (!s2_mode || s2_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            out_vld <= 1'b0;
            fc_open <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_vld;
            s2_vld <= s1_vld;
            out_vld <= emit;
            if (s2_vld)
                fc_open <= s2_mode && !s2_last;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mode <= mode;
            s1_first <= in_first;
            s1_last <= in_last;
            s1_en <= lane_en;
            s1_img <= img;
            s1_ker <= ker;
            s1_psum <= psum;
            s2_mode <= s1_mode;
            s2_first <= s1_first;
            s2_last <= s1_last;
            s2_psum <= s1_psum;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int K = i / LANES_PER_KER;
        logic [DATA_W-1:0] a, b;
        logic [PW2-1:0] ax, bx, mul, prod;
        logic [ACC_W-1:0] acc, base, sum, res;
        logic [QT_W-1:0] qt;
        logic [OUT_W-1:0] q, q_r;
        logic sat_hi, sat_lo, sat;
        assign a = s1_img[i*DATA_W +: DATA_W];
        assign b = s1_ker[K*DATA_W +: DATA_W];
        assign ax = {{DATA_W{a[DATA_W-1]}}, a};
        assign bx = {{DATA_W{b[DATA_W-1]}}, b};
        assign mul = ax * bx;
        // CONV adds the external partial sum; FC restarts from zero when no sum is open
        assign base = !s2_mode ? {{(ACC_W-PSUM_W){s2_psum[i*PSUM_W+PSUM_W-1]}}, s2_psum[i*PSUM_W +: PSUM_W]}
                    : (s2_first || !fc_open) ? '0 : acc;
        assign sum = base + {{(ACC_W-PW2){prod[PW2-1]}}, prod};
        // floor(x / 2^F) plus the half bit is round-half-up
        assign qt = {sum[ACC_W-1], sum[ACC_W-1:FRAC_W]} + {{(QT_W-1){1'b0}}, sum[FRAC_W-1]};
        assign sat_hi = !qt[QT_W-1] && |qt[QT_W-2:OUT_W-1];
        assign sat_lo = qt[QT_W-1] && !(&qt[QT_W-2:OUT_W-1]);
        assign q = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : qt[OUT_W-1:0];
        always_ff @(posedge clk) begin
            if (adv)
                prod <= s1_en[i] ? mul : '0;
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc <= '0;
                res <= '0;
                q_r <= '0;
                sat <= 1'b0;
            end else if (adv && s2_vld) begin
                if (s2_mode && !s2_last)
                    acc <= sum;
                if (emit) begin
                    res <= sum;
                    q_r <= q;
                    sat <= sat_hi || sat_lo;
                end
            end
        end
        assign acc_out[i*ACC_W +: ACC_W] = res;
        assign q_out[i*OUT_W +: OUT_W] = q_r;
        assign sat_flag[i] = sat;
    end
endmodule

// File: tb/tb_mac_array_acc.sv
// tb_mac_array_acc: table vectors, corner sequences and randomized traffic against a queue-based reference model
module tb_mac_array_acc;
    localparam int LANES = 120, DW = 16, LPK = 8, KN = 15, PW = 28, AW = 40, OW = 16, FW = 8;
    localparam longint QMAX = (longint'(1) <<< (OW-1)) - 1;
    localparam longint QMIN = -(longint'(1) <<< (OW-1));

    typedef struct {
        bit m, f, l, en;
        int lane;
        longint img_v, ker_v, psum_v, e_acc, e_q;
        bit e_sat;
    } vec_t;

    logic clk = 0, rst_n = 0, mode = 0, in_vld = 0, in_first = 0, in_last = 0, out_rdy = 1;
    logic in_rdy, out_vld, busy;
    logic [LANES-1:0] lane_en = '1;
    logic [LANES-1:0] sat_flag;
    logic [LANES*DW-1:0] img = '0;
    logic [KN*DW-1:0] ker = '0;
    logic [LANES*PW-1:0] psum = '0;
    logic [LANES*AW-1:0] acc_out;
    logic [LANES*OW-1:0] q_out;

    int n_vec = 0, n_err = 0, n_out = 0, n_acc = 0;
    bit m_open = 0;
    longint m_acc[LANES];
    logic [LANES*AW-1:0] m_q[$];

    mac_array_acc #(.LANES(LANES), .DATA_W(DW), .LANES_PER_KER(LPK), .KER_NUM(KN),
                    .PSUM_W(PW), .ACC_W(AW), .OUT_W(OW), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_first(in_first), .in_last(in_last), .lane_en(lane_en), .img(img), .ker(ker),
        .psum(psum), .out_vld(out_vld), .out_rdy(out_rdy), .acc_out(acc_out), .q_out(q_out),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint sx(longint v, int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint qraw(longint a);
        return (a + (longint'(1) <<< (FW - 1))) >>> FW;
    endfunction

    function automatic longint qexp(longint a);
        longint t = qraw(a);
        return t > QMAX ? QMAX : (t < QMIN ? QMIN : t);
    endfunction

    function automatic bit qsat(longint a);
        return qraw(a) > QMAX || qraw(a) < QMIN;
    endfunction

    function automatic longint lane_acc(int l);
        return sx(acc_out[l*AW +: AW], AW);
    endfunction

    function automatic longint lane_q(int l);
        return sx(q_out[l*OW +: OW], OW);
    endfunction

    function automatic vec_t mk(bit m, bit f, bit l, bit en, int lane, longint iv, longint kv,
                                longint pv, longint ea, longint eq, bit es);
        vec_t v;
        v.m = m; v.f = f; v.l = l; v.en = en; v.lane = lane;
        v.img_v = iv; v.ker_v = kv; v.psum_v = pv; v.e_acc = ea; v.e_q = eq; v.e_sat = es;
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_accept();
        logic [LANES*AW-1:0] v;
        bit start;
        longint p;
        v = '0;
        n_acc++;
        start = in_first || !m_open;
        for (int i = 0; i < LANES; i++) begin
            p = lane_en[i] ? sx(img[i*DW +: DW], DW) * sx(ker[(i/LPK)*DW +: DW], DW) : 0;
            if (!mode)
                v[i*AW +: AW] = AW'(sx(psum[i*PW +: PW], PW) + p);
            else begin
                m_acc[i] = sx((start ? 0 : m_acc[i]) + p, AW);
                v[i*AW +: AW] = AW'(m_acc[i]);
            end
        end
        if (!mode || in_last)
            m_q.push_back(v);
        m_open = mode && !in_last;
    endtask

    task automatic check_out();
        logic [LANES*AW-1:0] e;
        int ba, bq, bs, ia, iq, is;
        longint ea;
        if (m_q.size() == 0) begin
            chk("out_vld with no pending model result", out_vld, 0);
            return;
        end
        e = m_q.pop_front();
        n_out++;
        ba = -1; bq = -1; bs = -1;
        for (int i = 0; i < LANES; i++) begin
            ea = sx(e[i*AW +: AW], AW);
            if (ba < 0 && lane_acc(i) != ea) ba = i;
            if (bq < 0 && lane_q(i) != qexp(ea)) bq = i;
            if (bs < 0 && sat_flag[i] !== qsat(ea)) bs = i;
        end
        ia = ba < 0 ? 0 : ba;
        iq = bq < 0 ? 0 : bq;
        is = bs < 0 ? 0 : bs;
        chk($sformatf("sb acc_out lane%0d", ia), lane_acc(ia), sx(e[ia*AW +: AW], AW));
        chk($sformatf("sb q_out lane%0d", iq), lane_q(iq), qexp(sx(e[iq*AW +: AW], AW)));
        chk($sformatf("sb sat_flag lane%0d", is), sat_flag[is], qsat(sx(e[is*AW +: AW], AW)));
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_open = 0;
        end else begin
            if (out_vld && out_rdy) check_out();
            if (in_vld && in_rdy) model_accept();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_vld && cyc < 12) begin
            tick();
            cyc++;
        end
        if (!out_vld) chk("timeout waiting for out_vld", out_vld, 1);
    endtask

    task automatic fill(longint iv, longint kv, longint pv);
        lane_en = '1;
        for (int i = 0; i < LANES; i++) begin
            img[i*DW +: DW] = DW'(iv);
            psum[i*PW +: PW] = PW'(pv);
        end
        for (int i = 0; i < KN; i++) ker[i*DW +: DW] = DW'(kv);
    endtask

    task automatic rand_beat();
        for (int i = 0; i < LANES; i++) begin
            img[i*DW +: DW] = DW'($urandom);
            psum[i*PW +: PW] = PW'($urandom);
            lane_en[i] = ($urandom_range(0, 7) != 0);
        end
        for (int i = 0; i < KN; i++) ker[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic drive_vec(vec_t v);
        img = '0; ker = '0; psum = '0; lane_en = '1;
        mode = v.m; in_first = v.f; in_last = v.l;
        lane_en[v.lane] = v.en;
        img[v.lane*DW +: DW] = DW'(v.img_v);
        ker[(v.lane/LPK)*DW +: DW] = DW'(v.ker_v);
        psum[v.lane*PW +: PW] = PW'(v.psum_v);
        in_vld = 1;
    endtask

    initial begin
        vec_t tbl[11];
        int lat, base, acc0, rv[4];
        bit held;
        logic [LANES*AW-1:0] snap;
        tbl[0]  = mk(0, 0, 0, 1, 0,   3,      -4,     100,      88,           0,      0);
        tbl[1]  = mk(0, 0, 0, 1, 0,   -32768, -32768, 0,        1073741824,   32767,  1);
        tbl[2]  = mk(0, 0, 0, 1, 0,   -32768, 32767,  -32768,   -1073741824,  -32768, 1);
        tbl[3]  = mk(0, 0, 0, 1, 0,   1,      383,    0,        383,          1,      0);
        tbl[4]  = mk(0, 0, 0, 1, 0,   1,      384,    0,        384,          2,      0);
        tbl[5]  = mk(0, 0, 0, 0, 5,   5,      5,      7,        7,            0,      0);
        tbl[6]  = mk(0, 0, 0, 1, 0,   0,      0,      -129,     -129,         -1,     0);
        tbl[7]  = mk(0, 0, 0, 1, 0,   0,      0,      -128,     -128,         0,      0);
        tbl[8]  = mk(0, 0, 0, 1, 119, -2,     1000,   5,        -1995,        -8,     0);
        tbl[9]  = mk(1, 1, 1, 1, 0,   100,    -7,     0,        -700,         -3,     0);
        tbl[10] = mk(0, 0, 0, 1, 0,   0,      0,      -134217728, -134217728, -32768, 1);
        rv[0] = 10; rv[1] = 20; rv[2] = 30; rv[3] = 40;

        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        chk("reset out_vld", out_vld, 0);
        chk("reset busy", busy, 0);
        chk("reset in_rdy", in_rdy, 1);
        chk("reset sat_flag", sat_flag, 0);
        chk("reset acc_out zero", acc_out == '0, 1);
        chk("reset q_out zero", q_out == '0, 1);

        foreach (tbl[k]) begin
            drive_vec(tbl[k]);
            tick();
            in_vld = 0; in_first = 0; in_last = 0;
            wait_out(lat);
            chk($sformatf("vec%0d latency", k), lat + 1, 3);
            chk($sformatf("vec%0d acc_out", k), lane_acc(tbl[k].lane), tbl[k].e_acc);
            chk($sformatf("vec%0d q_out", k), lane_q(tbl[k].lane), tbl[k].e_q);
            chk($sformatf("vec%0d sat_flag", k), sat_flag[tbl[k].lane], tbl[k].e_sat);
            tick();
        end

        // four-beat FC dot product
        fill(256, 256, 0);
        mode = 1; in_vld = 1;
        for (int b = 0; b < 4; b++) begin
            in_first = (b == 0); in_last = (b == 3);
            tick();
        end
        in_vld = 0; in_first = 0; in_last = 0;
        base = n_out;
        wait_out(lat);
        chk("fc4 acc_out lane0", lane_acc(0), 262144);
        chk("fc4 acc_out lane77", lane_acc(77), 262144);
        chk("fc4 q_out lane0", lane_q(0), 1024);
        chk("fc4 sat_flag lane0", sat_flag[0], 0);
        repeat (5) tick();
        chk("fc4 output count", n_out - base, 1);

        // backpressure on a 5-beat CONV stream
        mode = 0; in_first = 0; in_last = 0;
        base = n_out; acc0 = n_acc; held = 0;
        rand_beat();
        in_vld = 1;
        for (int c = 0; c < 60 && n_out - base < 5; c++) begin
            if (out_vld && !held) begin
                held = 1; out_rdy = 0; snap = acc_out;
                for (int h = 0; h < 4; h++) begin
                    tick();
                    chk($sformatf("hold%0d in_rdy", h), in_rdy, 0);
                    chk($sformatf("hold%0d out_vld", h), out_vld, 1);
                    chk($sformatf("hold%0d acc_out stable", h), acc_out == snap, 1);
                end
                out_rdy = 1;
            end
            tick();
            if (n_acc - acc0 >= 5) in_vld = 0;
            else rand_beat();
        end
        in_vld = 0;
        chk("bp beats delivered", n_out - base, 5);
        chk("bp beats accepted", n_acc - acc0, 5);

        // FC restart by a second in_first mid-packet
        fill(0, 1, 0);
        mode = 1; in_vld = 1; base = n_out;
        for (int b = 0; b < 4; b++) begin
            fill(rv[b], 1, 0);
            in_first = (b == 0 || b == 2); in_last = (b == 3);
            tick();
        end
        in_vld = 0; in_first = 0; in_last = 0;
        wait_out(lat);
        chk("restart acc_out lane0", lane_acc(0), 70);
        repeat (5) tick();
        chk("restart output count", n_out - base, 1);

        // reset with an open sum and two beats in flight
        fill(2, 3, 0);
        mode = 1; in_vld = 1; in_first = 1; in_last = 0;
        tick();
        in_first = 0;
        tick();
        in_vld = 0;
        repeat (3) tick();
        chk("open sum busy", busy, 1);
        in_vld = 1;
        tick();
        in_last = 1;
        tick();
        in_vld = 0; in_last = 0;
        rst_n = 0; base = n_out;
        tick();
        rst_n = 1;
        chk("post-reset busy", busy, 0);
        chk("post-reset in_rdy", in_rdy, 1);
        chk("post-reset out_vld", out_vld, 0);
        repeat (5) tick();
        chk("post-reset output count", n_out - base, 0);
        chk("post-reset idle busy", busy, 0);
        fill(3, 2, 0);
        mode = 1; in_vld = 1; in_first = 0; in_last = 0;
        tick();
        fill(4, 2, 0);
        in_last = 1;
        tick();
        in_vld = 0; in_last = 0;
        wait_out(lat);
        chk("fresh packet acc_out lane0", lane_acc(0), 14);
        tick();

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            in_vld = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom_range(0, 1));
            in_first = ($urandom_range(0, 3) == 0);
            in_last = ($urandom_range(0, 2) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            rand_beat();
            tick();
        end
        in_vld = 0; out_rdy = 1;
        for (int c = 0; c < 20 && m_q.size() > 0; c++) tick();
        chk("drain pending results", m_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
